seg7_scan_reader: RTL

//  Monitors a multiplexed 7-segment display bus (one-hot digit select + shared

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_to_bcd.sv | 32 +++
 rtl/seg7_scan_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan reader.
// Segment patterns are {A,B,C,D,E,F,G} with bit 6 = A and active-high drive.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } digit_t;

  // Index of the highest set bit; meaningful only for a one-hot input of up to 32 digits.
  function automatic logic [4:0] onehot_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decoder: 7-segment pattern -> BCD digit with blank/error flags.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       err_o
);

  // Anything not in the table is an undecodable pattern.
  always_comb begin
    bcd_o   = BCD_ERR;
    blank_o = 1'b0;
    err_o   = 1'b1;
    case (seg_i)
      SEG_0:     begin bcd_o = 4'd0; err_o = 1'b0; end
      SEG_1:     begin bcd_o = 4'd1; err_o = 1'b0; end
      SEG_2:     begin bcd_o = 4'd2; err_o = 1'b0; end
      SEG_3:     begin bcd_o = 4'd3; err_o = 1'b0; end
      SEG_4:     begin bcd_o = 4'd4; err_o = 1'b0; end
      SEG_5:     begin bcd_o = 4'd5; err_o = 1'b0; end
      SEG_6:     begin bcd_o = 4'd6; err_o = 1'b0; end
      SEG_7:     begin bcd_o = 4'd7; err_o = 1'b0; end
      SEG_8:     begin bcd_o = 4'd8; err_o = 1'b0; end
      SEG_9:     begin bcd_o = 4'd9; err_o = 1'b0; end
      SEG_BLANK: begin bcd_o = BCD_BLANK; blank_o = 1'b1; err_o = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Passive reader for a multiplexed 7-segment bus: rebuilds each digit and
// publishes a complete frame atomically once every digit has been captured.
//
// state     | meaning
// ST_IDLE   | no valid (one-hot) digit select on the synchronized bus
// ST_SETTLE | valid select seen, waiting for (sel,seg) to hold steady
// ST_HELD   | current (sel,seg) already captured, waiting for the next change
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    sel_err
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  s_cur, prev_q;
  logic [NUM_DIGITS-1:0]         s_sel;
  logic [6:0]                    s_seg;
  logic                          same, sel_onehot, sel_bad;

  scan_state_e                   state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          capture;

  logic [NUM_DIGITS-1:0]         mask_q, mask_d, cap_vec;
  digit_t [NUM_DIGITS-1:0]       shadow_q;
  digit_t                        dec;
  logic                          publish;
  logic                          frame_valid_q, frame_valid_d;
  logic                          sel_err_q, sel_err_d;
  logic [4*NUM_DIGITS-1:0]       bcd_q;
  logic [NUM_DIGITS-1:0]         err_q, blank_q;

  assign s_cur      = sync_q[SYNC_STAGES-1];
  assign s_sel      = s_cur[W-1:7];
  assign s_seg      = s_cur[6:0];
  assign same       = (s_cur == prev_q);
  assign sel_onehot = $onehot(s_sel);
  assign sel_bad    = (s_sel != '0) && !sel_onehot;

  seg7_to_bcd u_dec (
    .seg_i   (s_seg),
    .bcd_o   (dec.bcd),
    .blank_o (dec.blank),
    .err_o   (dec.err)
  );

  // Synchronize select and segments together as one vector, and keep the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dig_sel, seg_in};
      prev_q <= s_cur;
    end
  end

  // FSM state and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: cnt_q counts matching compares, so the pair has been held for cnt_q+2
  // cycles when the current compare also matches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_onehot) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = sel_onehot ? ST_SETTLE : ST_IDLE;
        end else if (int'(cnt_q) + 2 >= SETTLE_CYCLES) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = sel_onehot ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  // Mask bookkeeping: a full mask publishes on the next edge; clear wins over everything.
  always_comb begin
    publish       = (mask_q == '1);
    cap_vec       = capture ? s_sel : '0;
    mask_d        = publish ? cap_vec : (mask_q | cap_vec);
    frame_valid_d = publish;
    sel_err_d     = sel_err_q | sel_bad;
    if (clear) begin
      mask_d        = '0;
      frame_valid_d = 1'b0;
      sel_err_d     = 1'b0;
    end
  end

  // Shadow capture and atomic publish of the completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      shadow_q      <= '0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      bcd_q         <= '0;
      err_q         <= '0;
      blank_q       <= '0;
    end else begin
      mask_q        <= mask_d;
      frame_valid_q <= frame_valid_d;
      sel_err_q     <= sel_err_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_vec[i]) shadow_q[i] <= dec;
        if (frame_valid_d) begin
          bcd_q[4*i +: 4] <= shadow_q[i].bcd;
          err_q[i]        <= shadow_q[i].err;
          blank_q[i]      <= shadow_q[i].blank;
        end
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign blank       = blank_q;
  assign frame_valid = frame_valid_q;
  assign sel_err     = sel_err_q;

endmodule
